// File: rtl/wb_bram_arbiter_pkg.sv
// Shared bus widths, arbiter state encoding and grant helpers for the
// two-master Wishbone block-RAM arbiter.
package wb_bram_arbiter_pkg;

   localparam int WB_ADR_W = 32;
   localparam int WB_DAT_W = 32;
   localparam int WB_SEL_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUS0 = 2'b01,
      ST_BUS1 = 2'b10
   } arb_state_e;

   // Round-robin pick: on a tie the master that did not own the bus last wins.
   function automatic arb_state_e arb_pick(input logic req0, input logic req1,
                                           input logic last);
      arb_state_e pick;
      pick = ST_IDLE;
      if (req0 && req1) begin
         pick = last ? ST_BUS0 : ST_BUS1;
      end else if (req0) begin
         pick = ST_BUS0;
      end else if (req1) begin
         pick = ST_BUS1;
      end
      return pick;
   endfunction

   function automatic logic [1:0] state_gnt(input arb_state_e st);
      logic [1:0] gnt;
      gnt = 2'b00;
      case (st)
         ST_BUS0: gnt = 2'b01;
         ST_BUS1: gnt = 2'b10;
         default: gnt = 2'b00;
      endcase
      return gnt;
   endfunction

endpackage

// File: rtl/wb_bram_arbiter_if.sv
// One Wishbone classic link; the arbiter is a slave towards each master
// and a master towards the block-RAM port.
interface wb_bram_arbiter_if;
   import wb_bram_arbiter_pkg::*;

   logic                cyc;
   logic                stb;
   logic                we;
   logic [WB_ADR_W-1:0] adr;
   logic [WB_DAT_W-1:0] dat_w;
   logic [WB_SEL_W-1:0] sel;
   logic                ack;
   logic                err;
   logic [WB_DAT_W-1:0] dat_r;

   modport master (
      output cyc, stb, we, adr, dat_w, sel,
      input  ack, err, dat_r
   );

   modport slave (
      input  cyc, stb, we, adr, dat_w, sel,
      output ack, err, dat_r
   );

endinterface

// File: rtl/wb_bram_arbiter_watchdog.sv
// Access watchdog: counts granted strobe cycles without ACK and emits a
// single-cycle fire pulse once TIMEOUT cycles have elapsed.
module wb_watchdog #(
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr,
   input  logic busy,
   input  logic ack,
   output logic fire
);

   logic [TO_W-1:0] cnt_q, cnt_d;

   // NOTE: every variable written here gets a default first, so no path
   // through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      fire  = (TIMEOUT > 0) && busy && (cnt_q == TO_W'(TIMEOUT - 1));
      cnt_d = cnt_q;
      if (clr || ack || fire) begin
         cnt_d = '0;
      end else if (busy) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops
   // sample their inputs from the same pre-edge values.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_bram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a single-port
// block RAM; grant is held for a whole CYC, watchdog answers with ERR.
module wb_bram_arbiter
   import wb_bram_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   wb_bram_arbiter_if.slave    m0,
   wb_bram_arbiter_if.slave    m1,
   wb_bram_arbiter_if.master   s,
   output logic [1:0]          gnt_o
);

   arb_state_e state_q, state_d;
   logic       last_q, last_d;
   logic       g_cyc;
   logic       g_stb;
   logic       wd_fire;

   // ---------------------------------------------------------------
   // Grant FSM: release re-arbitrates immediately, so a waiting master
   // takes over on the same edge without passing through IDLE.
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         ST_IDLE: begin
            state_d = arb_pick(m0.cyc, m1.cyc, last_q);
         end
         ST_BUS0: begin
            if (!m0.cyc) begin
               last_d  = 1'b0;
               state_d = arb_pick(1'b0, m1.cyc, 1'b0);
            end
         end
         ST_BUS1: begin
            if (!m1.cyc) begin
               last_d  = 1'b1;
               state_d = arb_pick(m0.cyc, 1'b0, 1'b1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   // ---------------------------------------------------------------
   // Bus routing: purely combinational from the grant, so ACK reaches
   // the master in the cycle the RAM raises it.
   // ---------------------------------------------------------------
   always_comb begin
      s.cyc    = 1'b0;
      s.stb    = 1'b0;
      s.we     = 1'b0;
      s.adr    = '0;
      s.dat_w  = '0;
      s.sel    = '0;
      m0.ack   = 1'b0;
      m0.err   = 1'b0;
      m1.ack   = 1'b0;
      m1.err   = 1'b0;
      m0.dat_r = s.dat_r;
      m1.dat_r = s.dat_r;
      g_cyc    = 1'b0;
      g_stb    = 1'b0;
      unique case (state_q)
         ST_BUS0: begin
            g_cyc   = m0.cyc;
            g_stb   = m0.stb;
            s.cyc   = m0.cyc;
            s.stb   = m0.stb & ~wd_fire;
            s.we    = m0.we;
            s.adr   = m0.adr;
            s.dat_w = m0.dat_w;
            s.sel   = m0.sel;
            m0.ack  = s.ack;
            m0.err  = wd_fire & ~s.ack;
         end
         ST_BUS1: begin
            g_cyc   = m1.cyc;
            g_stb   = m1.stb;
            s.cyc   = m1.cyc;
            s.stb   = m1.stb & ~wd_fire;
            s.we    = m1.we;
            s.adr   = m1.adr;
            s.dat_w = m1.dat_w;
            s.sel   = m1.sel;
            m1.ack  = s.ack;
            m1.err  = wd_fire & ~s.ack;
         end
         default: begin
         end
      endcase
   end

   assign gnt_o = state_gnt(state_q);

   // A grant change always passes through a cycle with the owner's CYC low
   // (or IDLE), so clearing on ~g_cyc also clears on every grant change.
   wb_watchdog #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_watchdog (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr     (~g_cyc),
      .busy    (g_cyc & g_stb),
      .ack     (s.ack),
      .fire    (wd_fire)
   );

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// Directed self-checking bench for wb_bram_arbiter: grant, round robin,
// watchdog, asynchronous reset and locked multi-beat cycles.
module tb_wb_bram_arbiter;

   logic       clk;
   logic       rst_n;
   logic [1:0] gnt;
   int         n_checks;
   int         n_fail;

   wb_bram_arbiter_if m0_if ();
   wb_bram_arbiter_if m1_if ();
   wb_bram_arbiter_if s_if ();

   wb_bram_arbiter #(
      .TIMEOUT (16),
      .TO_W    (5)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .m0      (m0_if),
      .m1      (m1_if),
      .s       (s_if),
      .gnt_o   (gnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic clk_step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.we = 1'b0;
      m0_if.adr = '0;   m0_if.dat_w = '0; m0_if.sel = '0;
      m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.we = 1'b0;
      m1_if.adr = '0;   m1_if.dat_w = '0; m1_if.sel = '0;
      s_if.ack  = 1'b0; s_if.err = 1'b0;  s_if.dat_r = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      clk_step();
      clk_step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
      m1_if.cyc = 1'b1; m1_if.stb = 1'b1;
      s_if.ack  = 1'b1;
      clk_step();
      @(negedge clk);
      n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rst_gnt got=%b exp=00", gnt); end
      n_checks++; if (s_if.cyc !== 1'b0) begin n_fail++; $display("FAIL rst_s_cyc got=%b exp=0", s_if.cyc); end
      n_checks++; if (s_if.stb !== 1'b0) begin n_fail++; $display("FAIL rst_s_stb got=%b exp=0", s_if.stb); end
      n_checks++; if ({m0_if.ack, m1_if.ack} !== 2'b00) begin n_fail++; $display("FAIL rst_ack got=%b exp=00", {m0_if.ack, m1_if.ack}); end
      n_checks++; if ({m0_if.err, m1_if.err} !== 2'b00) begin n_fail++; $display("FAIL rst_err got=%b exp=00", {m0_if.err, m1_if.err}); end
      idle_inputs();
      rst_n = 1'b1;
   endtask

   task automatic test_read();
      do_reset();
      clk_step();
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.we = 1'b0;
      m0_if.adr = 32'h0000_0010; m0_if.sel = 4'hF;
      @(negedge clk);
      n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rd_latency_gnt got=%b exp=00", gnt); end
      clk_step();
      @(negedge clk);
      n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rd_gnt got=%b exp=01", gnt); end
      n_checks++; if ({s_if.cyc, s_if.stb, s_if.we} !== 3'b110) begin n_fail++; $display("FAIL rd_s_ctl got=%b exp=110", {s_if.cyc, s_if.stb, s_if.we}); end
      n_checks++; if (s_if.adr !== 32'h0000_0010) begin n_fail++; $display("FAIL rd_s_adr got=%h exp=00000010", s_if.adr); end
      n_checks++; if (m0_if.ack !== 1'b0) begin n_fail++; $display("FAIL rd_early_ack got=%b exp=0", m0_if.ack); end
      clk_step();
      clk_step();
      s_if.ack = 1'b1; s_if.dat_r = 32'hDEAD_BEEF;
      @(negedge clk);
      n_checks++; if (m0_if.ack !== 1'b1) begin n_fail++; $display("FAIL rd_ack got=%b exp=1", m0_if.ack); end
      n_checks++; if (m0_if.dat_r !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_dat got=%h exp=deadbeef", m0_if.dat_r); end
      n_checks++; if (m1_if.dat_r !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_dat_bcast got=%h exp=deadbeef", m1_if.dat_r); end
      n_checks++; if (m1_if.ack !== 1'b0) begin n_fail++; $display("FAIL rd_m1_ack got=%b exp=0", m1_if.ack); end
      n_checks++; if (m0_if.err !== 1'b0) begin n_fail++; $display("FAIL rd_err got=%b exp=0", m0_if.err); end
      clk_step();
      s_if.ack = 1'b0; m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
      @(negedge clk);
      n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rd_release_gnt got=%b exp=01", gnt); end
      n_checks++; if (s_if.cyc !== 1'b0) begin n_fail++; $display("FAIL rd_release_cyc got=%b exp=0", s_if.cyc); end
      clk_step();
      s_if.ack = 1'b1;
      @(negedge clk);
      n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rd_idle_gnt got=%b exp=00", gnt); end
      n_checks++; if ({m0_if.ack, m1_if.ack} !== 2'b00) begin n_fail++; $display("FAIL rd_idle_ack got=%b exp=00", {m0_if.ack, m1_if.ack}); end
      s_if.ack = 1'b0;
   endtask

   task automatic test_simultaneous();
      do_reset();
      clk_step();
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 32'h0000_0100;
      m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 32'h0000_0200;
      @(negedge clk);
      n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL sim_idle_gnt got=%b exp=00", gnt); end
      clk_step();
      s_if.ack = 1'b1;
      @(negedge clk);
      n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL sim_first_gnt got=%b exp=01", gnt); end
      n_checks++; if (s_if.adr !== 32'h0000_0100) begin n_fail++; $display("FAIL sim_first_adr got=%h exp=00000100", s_if.adr); end
      n_checks++; if ({m0_if.ack, m1_if.ack} !== 2'b10) begin n_fail++; $display("FAIL sim_first_ack got=%b exp=10", {m0_if.ack, m1_if.ack}); end
      clk_step();
      s_if.ack = 1'b0; m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
      @(negedge clk);
      n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL sim_drop_gnt got=%b exp=01", gnt); end
      clk_step();
      s_if.ack = 1'b1;
      @(negedge clk);
      n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL sim_handover_gnt got=%b exp=10", gnt); end
      n_checks++; if (s_if.adr !== 32'h0000_0200) begin n_fail++; $display("FAIL sim_second_adr got=%h exp=00000200", s_if.adr); end
      n_checks++; if ({m0_if.ack, m1_if.ack} !== 2'b01) begin n_fail++; $display("FAIL sim_second_ack got=%b exp=01", {m0_if.ack, m1_if.ack}); end
      clk_step();
      s_if.ack = 1'b0; m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
      clk_step();
      @(negedge clk);
      n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL sim_final_gnt got=%b exp=00", gnt); end
   endtask

   task automatic test_round_robin();
      logic       drop0;
      logic       drop1;
      logic [1:0] exp_g;
      logic       exp_ack;
      do_reset();
      drop0 = 1'b0;
      drop1 = 1'b0;
      for (int k = 0; k <= 8; k++) begin
         clk_step();
         m0_if.cyc = ~drop0; m0_if.stb = ~drop0;
         m1_if.cyc = ~drop1; m1_if.stb = ~drop1;
         #1;
         s_if.ack = s_if.cyc & s_if.stb;
         @(negedge clk);
         exp_g   = (k == 0) ? 2'b00 : ((((k - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10);
         exp_ack = (k % 2 == 1);
         n_checks++; if (gnt !== exp_g) begin n_fail++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", k, gnt, exp_g); end
         n_checks++; if ({m1_if.ack, m0_if.ack} !== (exp_ack ? exp_g : 2'b00)) begin n_fail++; $display("FAIL rr_ack[%0d] got=%b exp=%b", k, {m1_if.ack, m0_if.ack}, exp_ack ? exp_g : 2'b00); end
         drop0 = m0_if.ack;
         drop1 = m1_if.ack;
      end
      idle_inputs();
   endtask

   task automatic test_watchdog();
      do_reset();
      clk_step();
      m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 32'h0000_0BAD;
      @(negedge clk);
      n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL wd_idle_gnt got=%b exp=00", gnt); end
      for (int k = 1; k <= 33; k++) begin
         clk_step();
         s_if.ack = (k == 32);
         @(negedge clk);
         n_checks++; if (m1_if.err !== (k == 16)) begin n_fail++; $display("FAIL wd_err[%0d] got=%b exp=%b", k, m1_if.err, (k == 16)); end
         n_checks++; if (s_if.stb !== (k != 16 && k != 32)) begin n_fail++; $display("FAIL wd_stb[%0d] got=%b exp=%b", k, s_if.stb, (k != 16 && k != 32)); end
         n_checks++; if (m1_if.ack !== (k == 32)) begin n_fail++; $display("FAIL wd_ack[%0d] got=%b exp=%b", k, m1_if.ack, (k == 32)); end
         n_checks++; if (m0_if.err !== 1'b0) begin n_fail++; $display("FAIL wd_m0_err[%0d] got=%b exp=0", k, m0_if.err); end
      end
      idle_inputs();
      clk_step();
   endtask

   task automatic test_reset_mid();
      do_reset();
      clk_step();
      m1_if.cyc = 1'b1; m1_if.stb = 1'b1;
      clk_step();
      @(negedge clk);
      n_checks++; if ({gnt, s_if.cyc, s_if.stb} !== 4'b1011) begin n_fail++; $display("FAIL rm_pre got=%b exp=1011", {gnt, s_if.cyc, s_if.stb}); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if ({s_if.cyc, s_if.stb} !== 2'b00) begin n_fail++; $display("FAIL rm_async_drop got=%b exp=00", {s_if.cyc, s_if.stb}); end
      n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rm_async_gnt got=%b exp=00", gnt); end
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
      clk_step();
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rm_release_gnt got=%b exp=00", gnt); end
      clk_step();
      @(negedge clk);
      n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rm_first_gnt got=%b exp=01", gnt); end
      idle_inputs();
      clk_step();
   endtask

   task automatic test_locked();
      do_reset();
      clk_step();
      m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.we = 1'b1; m1_if.sel = 4'b0011;
      m1_if.adr = 32'h0000_0300; m1_if.dat_w = 32'h0000_00A0;
      for (int b = 0; b < 3; b++) begin
         clk_step();
         m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.we = 1'b0;
         m0_if.adr = 32'h0000_0040; m0_if.sel = 4'hF;
         m1_if.adr = 32'h0000_0300 + 32'(4 * b);
         m1_if.dat_w = 32'h0000_00A0 + 32'(b);
         s_if.ack = 1'b1;
         @(negedge clk);
         n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL lk_gnt[%0d] got=%b exp=10", b, gnt); end
         n_checks++; if (s_if.sel !== 4'b0011) begin n_fail++; $display("FAIL lk_sel[%0d] got=%b exp=0011", b, s_if.sel); end
         n_checks++; if (s_if.we !== 1'b1) begin n_fail++; $display("FAIL lk_we[%0d] got=%b exp=1", b, s_if.we); end
         n_checks++; if (s_if.dat_w !== 32'h0000_00A0 + 32'(b)) begin n_fail++; $display("FAIL lk_dat[%0d] got=%h exp=%h", b, s_if.dat_w, 32'h0000_00A0 + 32'(b)); end
         n_checks++; if ({m0_if.ack, m1_if.ack} !== 2'b01) begin n_fail++; $display("FAIL lk_ack[%0d] got=%b exp=01", b, {m0_if.ack, m1_if.ack}); end
      end
      clk_step();
      s_if.ack = 1'b0; m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
      @(negedge clk);
      n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL lk_drop_gnt got=%b exp=10", gnt); end
      clk_step();
      @(negedge clk);
      n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL lk_m0_gnt got=%b exp=01", gnt); end
      n_checks++; if ({s_if.adr, s_if.sel} !== {32'h0000_0040, 4'hF}) begin n_fail++; $display("FAIL lk_m0_route got=%h/%b exp=00000040/1111", s_if.adr, s_if.sel); end
      idle_inputs();
      clk_step();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      idle_inputs();
      test_reset();
      test_read();
      test_simultaneous();
      test_round_robin();
      test_watchdog();
      test_reset_mid();
      test_locked();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
